ts_bus_sequencer: RTL

//  Owns the BDIR/BC/DI bus into the Turbosound-FM block and shares it between the CPU port and a

---
 rtl/ts_bus_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ts_bus_sequencer.sv
// Turbosound-FM bus owner: CPU passthrough plus snapshot/restore loader that
// expands each request into timed AY bus cycles and restores the CPU context.
module ts_bus_sequencer #(
    parameter int unsigned HOLD = 4,
    parameter int unsigned GAP  = 4
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       CPU_BDIR,
    input  logic       CPU_BC,
    input  logic [7:0] CPU_DI,
    input  logic       LD_REQ,
    input  logic       LD_CHIP,
    input  logic [7:0] LD_ADDR,
    input  logic [7:0] LD_DATA,
    output logic       LD_ACK,
    output logic       BDIR,
    output logic       BC,
    output logic [7:0] DO_BUS,
    output logic       BUSY,
    output logic       OVERRUN
);

    localparam int unsigned WIN = HOLD + GAP;
    localparam int unsigned CW  = $clog2(WIN);

    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_ADDR, S_DATA, S_RADDR, S_RSEL, S_REPLAY
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic           bdir_q, bc_q, busy_q, ld_ack_q, ovr_q;
    logic [7:0]     do_q;
    logic           cpu_bdir_q;
    logic [7:0]     sel_shadow_q, cpu_addr_q;
    logic           addr_chip_q, addr_valid_q;
    logic           pend_valid_q, pend_bc_q;
    logic [7:0]     pend_di_q;
    logic           ld_chip_q, skip_sel_q;
    logic [7:0]     ld_addr_q, ld_data_q;

    // Combinational helpers: CPU edge decode, shadow next values, next state and its bus payload
    logic           cpu_edge_c, busy_c, cap_c, sel_wr_c, addr_wr_c;
    logic [7:0]     sel_shadow_d, cpu_addr_d;
    logic           addr_chip_d, addr_valid_d;
    logic           pend_any_c, start_c, cyc_end_c, raddr_ok_c, repl_c;
    logic           chip_c;
    logic [7:0]     addr_c, data_c;
    state_t         tail_c, nxt_c;
    logic           ent_bc_c;
    logic [7:0]     ent_do_c;

    always_comb begin
        cpu_edge_c   = CPU_BDIR && !cpu_bdir_q;
        busy_c       = (state_q != S_IDLE);
        cap_c        = cpu_edge_c && busy_c;
        sel_wr_c     = cpu_edge_c && CPU_BC && (CPU_DI[7:3] == 5'b11111);
        addr_wr_c    = cpu_edge_c && CPU_BC && (CPU_DI[7:3] != 5'b11111);
        sel_shadow_d = sel_wr_c  ? CPU_DI : sel_shadow_q;
        cpu_addr_d   = addr_wr_c ? CPU_DI : cpu_addr_q;
        addr_chip_d  = addr_wr_c ? sel_shadow_q[0] : addr_chip_q;
        addr_valid_d = addr_valid_q || addr_wr_c;
        pend_any_c   = pend_valid_q || cap_c;
        start_c      = !busy_c && LD_REQ && !CPU_BDIR;
        cyc_end_c    = busy_c && (cnt_q == CW'(WIN - 1));
        raddr_ok_c   = addr_valid_d && (addr_chip_d == ld_chip_q);
        chip_c       = busy_c ? ld_chip_q : LD_CHIP;
        addr_c       = busy_c ? ld_addr_q : LD_ADDR;
        data_c       = busy_c ? ld_data_q : LD_DATA;
        tail_c       = pend_any_c ? S_REPLAY : S_IDLE;

        nxt_c = S_IDLE;
        case (state_q)
            S_IDLE:   nxt_c = (sel_shadow_q[0] == LD_CHIP) ? S_ADDR : S_SEL;
            S_SEL:    nxt_c = S_ADDR;
            S_ADDR:   nxt_c = S_DATA;
            S_DATA:   nxt_c = raddr_ok_c ? S_RADDR : (!skip_sel_q ? S_RSEL : tail_c);
            S_RADDR:  nxt_c = !skip_sel_q ? S_RSEL : tail_c;
            S_RSEL:   nxt_c = tail_c;
            S_REPLAY: nxt_c = tail_c;
            default:  nxt_c = S_IDLE;
        endcase
        repl_c = cyc_end_c && (nxt_c == S_REPLAY);

        ent_bc_c = CPU_BC;
        ent_do_c = CPU_DI;
        case (nxt_c)
            S_SEL:    begin ent_bc_c = 1'b1; ent_do_c = {sel_shadow_d[7:1], chip_c}; end
            S_ADDR:   begin ent_bc_c = 1'b1; ent_do_c = addr_c; end
            S_DATA:   begin ent_bc_c = 1'b0; ent_do_c = data_c; end
            S_RADDR:  begin ent_bc_c = 1'b1; ent_do_c = cpu_addr_d; end
            S_RSEL:   begin ent_bc_c = 1'b1; ent_do_c = sel_shadow_d; end
            S_REPLAY: begin
                ent_bc_c = pend_valid_q ? pend_bc_q : CPU_BC;
                ent_do_c = pend_valid_q ? pend_di_q : CPU_DI;
            end
            default:  begin ent_bc_c = CPU_BC; ent_do_c = CPU_DI; end
        endcase
    end

    // Sequencer FSM, shadows, pending slot and registered bus outputs
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bdir_q       <= 1'b0;
            bc_q         <= 1'b0;
            do_q         <= 8'h00;
            busy_q       <= 1'b0;
            ld_ack_q     <= 1'b0;
            ovr_q        <= 1'b0;
            cpu_bdir_q   <= 1'b0;
            sel_shadow_q <= 8'hFF;
            cpu_addr_q   <= 8'h00;
            addr_chip_q  <= 1'b0;
            addr_valid_q <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_bc_q    <= 1'b0;
            pend_di_q    <= 8'h00;
            ld_chip_q    <= 1'b0;
            skip_sel_q   <= 1'b0;
            ld_addr_q    <= 8'h00;
            ld_data_q    <= 8'h00;
        end else begin
            cpu_bdir_q   <= CPU_BDIR;
            sel_shadow_q <= sel_shadow_d;
            cpu_addr_q   <= cpu_addr_d;
            addr_chip_q  <= addr_chip_d;
            addr_valid_q <= addr_valid_d;
            ld_ack_q     <= 1'b0;
            ovr_q        <= 1'b0;

            // Pending slot: a replay frees it the same cycle a new write may land in it
            if (repl_c) begin
                pend_valid_q <= pend_valid_q && cap_c;
                if (cap_c) begin
                    pend_bc_q <= CPU_BC;
                    pend_di_q <= CPU_DI;
                end
            end else if (cap_c) begin
                if (pend_valid_q) begin
                    ovr_q <= 1'b1;
                end else begin
                    pend_valid_q <= 1'b1;
                    pend_bc_q    <= CPU_BC;
                    pend_di_q    <= CPU_DI;
                end
            end

            if (start_c) begin
                ld_chip_q  <= LD_CHIP;
                ld_addr_q  <= LD_ADDR;
                ld_data_q  <= LD_DATA;
                skip_sel_q <= (sel_shadow_q[0] == LD_CHIP);
                state_q    <= nxt_c;
                cnt_q      <= '0;
                busy_q     <= 1'b1;
                bdir_q     <= 1'b1;
                bc_q       <= ent_bc_c;
                do_q       <= ent_do_c;
            end else if (busy_c) begin
                if (cyc_end_c) begin
                    state_q <= nxt_c;
                    cnt_q   <= '0;
                    bc_q    <= ent_bc_c;
                    do_q    <= ent_do_c;
                    if (nxt_c == S_IDLE) begin
                        busy_q   <= 1'b0;
                        ld_ack_q <= 1'b1;
                        bdir_q   <= CPU_BDIR;
                    end else begin
                        bdir_q   <= 1'b1;
                    end
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(HOLD - 1)) begin
                        bdir_q <= 1'b0;
                    end
                end
            end else begin
                bdir_q <= CPU_BDIR;
                bc_q   <= CPU_BC;
                do_q   <= CPU_DI;
            end
        end
    end

    assign BDIR    = bdir_q;
    assign BC      = bc_q;
    assign DO_BUS  = do_q;
    assign BUSY    = busy_q;
    assign LD_ACK  = ld_ack_q;
    assign OVERRUN = ovr_q;

endmodule
